gray_ptr_ctrl: RTL and testbench

Parametrised Gray-coded pointer controller for one side of the asynchronous FIFO. It keeps a registered binary and Gray pointer pair and steps them on each accepted request. It compares its next pointer against the other domain's pointer, which arrives already synchronised, to produce a registered full flag (write side) or empty flag (read side), plus a registered fill level. Two instances, one per clock domain, form the FIFO's pointer logic around the dual-port RAM and the two-flop synchronisers.

---
 rtl/gray_ptr_ctrl.sv | 83 ++++++++
 tb/tb_gray_ptr_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gray_ptr_ctrl
// Brief    : One side of an async FIFO pointer pair: binary/Gray pointer,
//            registered full (MODE 0) or empty (MODE 1) flag and fill level.
// Revision : 1.0 - initial release
// ============================================================================
module gray_ptr_ctrl #(
  parameter int K    = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic [K:0]   remote_gray,
  output logic         accept,
  output logic [K-1:0] addr,
  output logic [K:0]   ptr_bin,
  output logic [K:0]   ptr_gray,
  output logic         flag,
  output logic [K:0]   level
);

  // The read side comes out of reset empty; the write side is not full.
  localparam logic c_FLAG_RST = (MODE == 1);

  logic [K:0] r_ptr_bin;
  logic [K:0] r_ptr_gray;
  logic [K:0] r_level;
  logic       r_flag;

  logic       w_accept;
  logic [K:0] w_bin_next;
  logic [K:0] w_gray_next;
  logic [K:0] w_rem_bin;
  logic [K:0] w_level_next;
  logic       w_flag_next;

  assign w_accept    = inc & ~r_flag;
  assign w_bin_next  = r_ptr_bin + {{K{1'b0}}, w_accept};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= K; gi++) begin : g_rem_dec
    assign w_rem_bin[gi] = ^(remote_gray >> gi);
  end

  if (MODE == 0) begin : g_wr_side
    // Full when we are exactly one lap ahead: top two Gray bits inverted.
    localparam logic [K:0] c_FULL_MASK = {(K+1){1'b1}} << (K-1);
    assign w_flag_next  = (w_gray_next == (remote_gray ^ c_FULL_MASK));
    assign w_level_next = w_bin_next - w_rem_bin;
  end else begin : g_rd_side
    assign w_flag_next  = (w_gray_next == remote_gray);
    assign w_level_next = w_rem_bin - w_bin_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_bin  <= '0;
      r_ptr_gray <= '0;
      r_level    <= '0;
      r_flag     <= c_FLAG_RST;
    end else begin
      if (w_accept) begin
        r_ptr_bin  <= w_bin_next;
        r_ptr_gray <= w_gray_next;
      end
      // Flag and level track remote moves even without a local request.
      r_flag  <= w_flag_next;
      r_level <= w_level_next;
    end
  end

  assign accept   = w_accept;
  assign addr     = r_ptr_bin[K-1:0];
  assign ptr_bin  = r_ptr_bin;
  assign ptr_gray = r_ptr_gray;
  assign flag     = r_flag;
  assign level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_ctrl.sv
`default_nettype none
// Bench for gray_ptr_ctrl, K=3: write-side and read-side instances checked
// against an occupancy model built from push/pop counts.
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc0 = 1'b0, inc1 = 1'b0;
  logic [3:0] rg0 = '0, rg1 = '0;
  logic       acc0, acc1, fl0, fl1;
  logic [2:0] addr0, addr1;
  logic [3:0] pb0, pb1, pg0, pg1, lv0, lv1;

  int checks = 0;
  int errors = 0;

  // Model: write side counts pushes (m0_w) vs remote pops (m0_r);
  // read side counts pops (m1_rd) vs remote pushes (m1_wr).
  int m0_w, m0_r, m0_level, m1_rd, m1_wr, m1_level;
  bit m0_flag, m1_flag;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.K(3), .MODE(0)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(inc0), .remote_gray(rg0),
    .accept(acc0), .addr(addr0), .ptr_bin(pb0), .ptr_gray(pg0),
    .flag(fl0), .level(lv0)
  );

  gray_ptr_ctrl #(.K(3), .MODE(1)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(inc1), .remote_gray(rg1),
    .accept(acc1), .addr(addr1), .ptr_bin(pb1), .ptr_gray(pg1),
    .flag(fl1), .level(lv1)
  );

  function automatic logic [3:0] g(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m0_w = 0; m0_r = 0; m0_level = 0; m0_flag = 1'b0;
    m1_rd = 0; m1_wr = 0; m1_level = 0; m1_flag = 1'b1;
  endtask

  task automatic tick();
    bit e0, e1;
    e0 = inc0 && !m0_flag;
    e1 = inc1 && !m1_flag;
    @(posedge clk);
    #1;
    m0_w += int'(e0);
    m0_level = m0_w - m0_r;
    m0_flag = (m0_level == 8);
    m1_rd += int'(e1);
    m1_level = m1_wr - m1_rd;
    m1_flag = (m1_level == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inc0 = 1'b0; inc1 = 1'b0; rg0 = '0; rg1 = '0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks += 8;
    if (fl0 !== 1'b0) begin errors++; $display("FAIL rst_fl0 got %0d want 0", fl0); end
    if (pg0 !== 4'b0000) begin errors++; $display("FAIL rst_pg0 got %b want 0000", pg0); end
    if (lv0 !== 4'd0) begin errors++; $display("FAIL rst_lv0 got %0d want 0", lv0); end
    if (pb0 !== 4'd0) begin errors++; $display("FAIL rst_pb0 got %0d want 0", pb0); end
    if (addr0 !== 3'd0) begin errors++; $display("FAIL rst_addr0 got %0d want 0", addr0); end
    if (fl1 !== 1'b1) begin errors++; $display("FAIL rst_fl1 got %0d want 1", fl1); end
    if (lv1 !== 4'd0) begin errors++; $display("FAIL rst_lv1 got %0d want 0", lv1); end
    if (pg1 !== 4'b0000) begin errors++; $display("FAIL rst_pg1 got %b want 0000", pg1); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      inc0 = 1'b1;
      #1;
      checks++;
      if (acc0 !== (i < 8)) begin errors++; $display("FAIL fill_acc i=%0d got %0d want %0d", i, acc0, (i < 8)); end
      tick();
      checks++;
      if (pb0 !== 4'(m0_w)) begin errors++; $display("FAIL fill_pb i=%0d got %0d want %0d", i, pb0, 4'(m0_w)); end
    end
    inc0 = 1'b0;
    checks += 4;
    if (fl0 !== 1'b1) begin errors++; $display("FAIL fill_flag got %0d want 1", fl0); end
    if (pb0 !== 4'd8) begin errors++; $display("FAIL fill_pb_end got %0d want 8", pb0); end
    if (pg0 !== 4'b1100) begin errors++; $display("FAIL fill_pg got %b want 1100", pg0); end
    if (lv0 !== 4'd8) begin errors++; $display("FAIL fill_lv got %0d want 8", lv0); end
  endtask

  task automatic test_drain();
    do_reset();
    m1_wr = 5;
    rg1 = 4'b0111;
    tick();
    checks += 2;
    if (fl1 !== 1'b0) begin errors++; $display("FAIL drain_fl_open got %0d want 0", fl1); end
    if (lv1 !== 4'd5) begin errors++; $display("FAIL drain_lv_open got %0d want 5", lv1); end
    for (int i = 1; i <= 5; i++) begin
      inc1 = 1'b1;
      #1;
      checks++;
      if (acc1 !== 1'b1) begin errors++; $display("FAIL drain_acc pop=%0d got %0d want 1", i, acc1); end
      tick();
      checks++;
      if (lv1 !== 4'(5 - i)) begin errors++; $display("FAIL drain_lv pop=%0d got %0d want %0d", i, lv1, 5 - i); end
    end
    checks += 3;
    if (fl1 !== 1'b1) begin errors++; $display("FAIL drain_empty got %0d want 1", fl1); end
    #1;
    if (acc1 !== 1'b0) begin errors++; $display("FAIL drain_acc6 got %0d want 0", acc1); end
    tick();
    if (pb1 !== 4'd5) begin errors++; $display("FAIL drain_pb_hold got %0d want 5", pb1); end
    inc1 = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    do_reset();
    prev = pg0;
    for (int i = 0; i < 20; i++) begin
      m0_r = (m0_w >= 2) ? m0_w - 2 : 0;
      rg0 = g(m0_r);
      inc0 = 1'b1;
      tick();
      checks += 4;
      if ($countones(pg0 ^ prev) != 1) begin errors++; $display("FAIL wrap_hamming i=%0d got %b from %b want one bit", i, pg0, prev); end
      if (pg0 !== g(m0_w)) begin errors++; $display("FAIL wrap_pg i=%0d got %b want %b", i, pg0, g(m0_w)); end
      if (pb0 !== 4'(m0_w)) begin errors++; $display("FAIL wrap_pb i=%0d got %0d want %0d", i, pb0, 4'(m0_w)); end
      if (fl0 !== 1'b0) begin errors++; $display("FAIL wrap_flag i=%0d got %0d want 0", i, fl0); end
      if (i == 15) begin
        checks += 2;
        if (pb0 !== 4'd0) begin errors++; $display("FAIL wrap_pb_zero got %0d want 0", pb0); end
        if (prev !== 4'b1000 || pg0 !== 4'b0000) begin errors++; $display("FAIL wrap_pg_step got %b->%b want 1000->0000", prev, pg0); end
      end
      prev = pg0;
    end
    inc0 = 1'b0;
  endtask

  task automatic test_full_release();
    do_reset();
    inc0 = 1'b1;
    repeat (8) tick();
    checks++;
    if (fl0 !== 1'b1) begin errors++; $display("FAIL rel_full got %0d want 1", fl0); end
    m0_r = 1;
    rg0 = 4'b0001;
    #1;
    checks++;
    if (acc0 !== 1'b0) begin errors++; $display("FAIL rel_acc got %0d want 0", acc0); end
    tick();
    checks += 3;
    if (fl0 !== 1'b0) begin errors++; $display("FAIL rel_flag got %0d want 0", fl0); end
    if (lv0 !== 4'd7) begin errors++; $display("FAIL rel_lv got %0d want 7", lv0); end
    if (pb0 !== 4'd8) begin errors++; $display("FAIL rel_pb got %0d want 8", pb0); end
    inc0 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_wr = 4;
    rg1 = g(4);
    inc0 = 1'b1;
    inc1 = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    rg0 = '0; rg1 = '0;
    model_reset();
    #1;
    checks += 7;
    if (pb0 !== 4'd0) begin errors++; $display("FAIL ares_pb0 got %0d want 0", pb0); end
    if (pg0 !== 4'd0) begin errors++; $display("FAIL ares_pg0 got %b want 0000", pg0); end
    if (lv0 !== 4'd0) begin errors++; $display("FAIL ares_lv0 got %0d want 0", lv0); end
    if (fl0 !== 1'b0) begin errors++; $display("FAIL ares_fl0 got %0d want 0", fl0); end
    if (pb1 !== 4'd0) begin errors++; $display("FAIL ares_pb1 got %0d want 0", pb1); end
    if (lv1 !== 4'd0) begin errors++; $display("FAIL ares_lv1 got %0d want 0", lv1); end
    if (fl1 !== 1'b1) begin errors++; $display("FAIL ares_fl1 got %0d want 1", fl1); end
    #2 rst_n = 1'b1;
    tick();
    checks += 2;
    if (pb0 !== 4'd1) begin errors++; $display("FAIL ares_restart got %0d want 1", pb0); end
    if (pb1 !== 4'd0) begin errors++; $display("FAIL ares_rd_hold got %0d want 0", pb1); end
    inc0 = 1'b0;
    inc1 = 1'b0;
  endtask

  task automatic test_random();
    int pinc, prem;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pinc = (c < 200) ? 70 : 30;
      prem = (c < 200) ? 30 : 70;
      inc0 = ($urandom_range(0, 99) < pinc);
      inc1 = ($urandom_range(0, 99) < prem);
      if (m0_r < m0_w && $urandom_range(0, 99) < prem) m0_r++;
      if (m1_wr - m1_rd < 8 && $urandom_range(0, 99) < pinc) m1_wr++;
      rg0 = g(m0_r);
      rg1 = g(m1_wr);
      #1;
      checks += 2;
      if (acc0 !== (inc0 && !m0_flag)) begin errors++; $display("FAIL rnd_acc0 c=%0d got %0d want %0d", c, acc0, inc0 && !m0_flag); end
      if (acc1 !== (inc1 && !m1_flag)) begin errors++; $display("FAIL rnd_acc1 c=%0d got %0d want %0d", c, acc1, inc1 && !m1_flag); end
      tick();
      checks += 10;
      if (pb0 !== 4'(m0_w)) begin errors++; $display("FAIL rnd_pb0 c=%0d got %0d want %0d", c, pb0, 4'(m0_w)); end
      if (pg0 !== g(m0_w)) begin errors++; $display("FAIL rnd_pg0 c=%0d got %b want %b", c, pg0, g(m0_w)); end
      if (addr0 !== 3'(m0_w)) begin errors++; $display("FAIL rnd_addr0 c=%0d got %0d want %0d", c, addr0, 3'(m0_w)); end
      if (fl0 !== m0_flag) begin errors++; $display("FAIL rnd_fl0 c=%0d got %0d want %0d", c, fl0, m0_flag); end
      if (lv0 !== 4'(m0_level)) begin errors++; $display("FAIL rnd_lv0 c=%0d got %0d want %0d", c, lv0, m0_level); end
      if (pb1 !== 4'(m1_rd)) begin errors++; $display("FAIL rnd_pb1 c=%0d got %0d want %0d", c, pb1, 4'(m1_rd)); end
      if (pg1 !== g(m1_rd)) begin errors++; $display("FAIL rnd_pg1 c=%0d got %b want %b", c, pg1, g(m1_rd)); end
      if (addr1 !== 3'(m1_rd)) begin errors++; $display("FAIL rnd_addr1 c=%0d got %0d want %0d", c, addr1, 3'(m1_rd)); end
      if (fl1 !== m1_flag) begin errors++; $display("FAIL rnd_fl1 c=%0d got %0d want %0d", c, fl1, m1_flag); end
      if (lv1 !== 4'(m1_level)) begin errors++; $display("FAIL rnd_lv1 c=%0d got %0d want %0d", c, lv1, m1_level); end
    end
    inc0 = 1'b0;
    inc1 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_release();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
